// File: rtl/sys_array_stream_ctrl.sv
// sys_array_stream_ctrl: run control, beat counting, output FIFO
// and error/watchdog handling between the control block and sys_array.

module sys_array_stream_ctrl #(
    parameter int M           = 2,
    parameter int N           = 2,
    parameter int K           = 2,
    parameter int BW          = 2,
    parameter int FIFO_DEPTH  = 4,
    parameter int TIMEOUT_CYC = 4096
) (
    input  logic             clk,
    input  logic             nrst,
    input  logic             ap_start,
    output logic             ap_done,
    output logic             ap_ready,
    output logic             ap_idle,
    output logic             ap_err,
    output logic [1:0]       err_code,
    input  logic             s_valid,
    output logic             s_ready,
    input  logic [BW*32-1:0] s_data,
    output logic             core_in_valid,
    output logic [BW*32-1:0] core_in_data,
    input  logic             core_in_ready,
    input  logic             core_out_valid,
    input  logic [BW*32-1:0] core_out_data,
    output logic             core_out_ready,
    input  logic             core_err,
    output logic             m_valid,
    input  logic             m_ready,
    output logic [BW*32-1:0] m_data,
    output logic             m_last
);

    localparam int IN_BEATS  = (M*K + K*N + BW - 1) / BW;
    localparam int OUT_BEATS = (M*N + BW - 1) / BW;
    localparam int IN_W      = $clog2(IN_BEATS + 1);
    localparam int OUT_W     = $clog2(OUT_BEATS + 1);
    localparam int TM_W      = $clog2(TIMEOUT_CYC + 1);
    localparam int AW        = $clog2(FIFO_DEPTH);
    localparam int DW        = BW*32;

    localparam logic [IN_W-1:0]  IN_LAST  = IN_W'(IN_BEATS - 1);
    localparam logic [OUT_W-1:0] OUT_LAST = OUT_W'(OUT_BEATS - 1);
    localparam logic [OUT_W-1:0] OUT_ALL  = OUT_W'(OUT_BEATS);
    localparam logic [TM_W-1:0]  TM_LAST  = TM_W'(TIMEOUT_CYC - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_DRAIN,
        S_DONE,
        S_ERR
    } state_t;

    state_t r_state;
    state_t w_state_nxt;

    logic [IN_W-1:0]  r_in_cnt;
    logic [OUT_W-1:0] r_out_cnt;
    logic [TM_W-1:0]  r_timer;
    logic [DW-1:0]    r_mem [FIFO_DEPTH];
    logic [AW:0]      r_wptr;
    logic [AW:0]      r_rptr;

    logic w_run;
    logic w_empty;
    logic w_full;
    logic w_s_hs;
    logic w_co_hs;
    logic w_m_hs;
    logic w_any_hs;
    logic w_timeout;
    logic w_err;
    logic w_flush;
    logic w_push;
    logic w_start;

    assign w_run     = (r_state == S_LOAD) || (r_state == S_DRAIN);
    assign w_start   = (r_state == S_IDLE) && ap_start;
    assign w_empty   = (r_wptr == r_rptr);
    assign w_full    = (r_wptr[AW] != r_rptr[AW]) &&
                       (r_wptr[AW-1:0] == r_rptr[AW-1:0]);
    assign w_s_hs    = s_valid && s_ready;
    assign w_co_hs   = core_out_valid && core_out_ready;
    assign w_m_hs    = m_valid && m_ready;
    assign w_any_hs  = w_s_hs || w_co_hs || w_m_hs;
    // Watchdog fires on the TIMEOUT_CYC-th consecutive idle cycle
    assign w_timeout = w_run && !w_any_hs && (r_timer == TM_LAST);
    assign w_err     = w_run && (core_err || w_timeout);
    assign w_flush   = w_err || (r_state == S_ERR);
    assign w_push    = w_run && w_co_hs && !w_flush;

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        unique case (r_state)
            S_IDLE: begin
                if (ap_start) w_state_nxt = S_LOAD;
            end
            S_LOAD: begin
                if (w_err) begin
                    w_state_nxt = S_ERR;
                end else if (w_s_hs && r_in_cnt == IN_LAST) begin
                    w_state_nxt = S_DRAIN;
                end
            end
            S_DRAIN: begin
                if (w_err) begin
                    w_state_nxt = S_ERR;
                end else if ((r_out_cnt == OUT_ALL) ||
                             (w_m_hs && r_out_cnt == OUT_LAST)) begin
                    w_state_nxt = S_DONE;
                end
            end
            S_DONE:  w_state_nxt = S_IDLE;
            S_ERR:   w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // Push is allowed into a full FIFO when the head pops the same cycle
    always_comb begin
        ap_idle        = 1'b0;
        ap_done        = 1'b0;
        s_ready        = 1'b0;
        core_in_valid  = 1'b0;
        core_out_ready = 1'b0;
        unique case (r_state)
            S_IDLE: begin
                ap_idle        = 1'b1;
                core_out_ready = 1'b1;
            end
            S_LOAD: begin
                s_ready        = core_in_ready;
                core_in_valid  = s_valid;
                core_out_ready = !w_full || m_ready;
            end
            S_DRAIN: begin
                core_out_ready = !w_full || m_ready;
            end
            S_DONE: begin
                ap_done = 1'b1;
            end
            S_ERR: begin
                ap_done        = 1'b1;
                core_out_ready = 1'b1;
            end
            default: begin
                ap_idle = 1'b0;
            end
        endcase
    end

    assign ap_ready     = ap_done;
    assign core_in_data = s_data;
    assign m_valid      = !w_empty;
    assign m_data       = m_valid ? r_mem[r_rptr[AW-1:0]] : '0;
    assign m_last       = m_valid && (r_out_cnt == OUT_LAST);

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            r_in_cnt  <= '0;
            r_out_cnt <= '0;
            r_timer   <= '0;
        end else if (w_start) begin
            r_in_cnt  <= '0;
            r_out_cnt <= '0;
            r_timer   <= '0;
        end else if (w_run) begin
            if (w_s_hs) r_in_cnt <= r_in_cnt + IN_W'(1);
            if (w_m_hs && r_out_cnt != OUT_ALL) begin
                r_out_cnt <= r_out_cnt + OUT_W'(1);
            end
            r_timer <= w_any_hs ? '0 : r_timer + TM_W'(1);
        end
    end

    // A stray core beat in IDLE overrides a clear on the same cycle
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            ap_err   <= 1'b0;
            err_code <= 2'b00;
        end else begin
            if (w_start) begin
                ap_err   <= 1'b0;
                err_code <= 2'b00;
            end
            if (w_err) begin
                ap_err   <= 1'b1;
                err_code <= core_err ? 2'b10 : 2'b01;
            end
            if (r_state == S_IDLE && core_out_valid) begin
                ap_err   <= 1'b1;
                err_code <= 2'b11;
            end
        end
    end

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            r_wptr <= '0;
            r_rptr <= '0;
        end else if (w_flush) begin
            r_wptr <= '0;
            r_rptr <= '0;
        end else begin
            if (w_push) r_wptr <= r_wptr + (AW+1)'(1);
            if (w_m_hs) r_rptr <= r_rptr + (AW+1)'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (w_push) r_mem[r_wptr[AW-1:0]] <= core_out_data;
    end

endmodule

// File: tb/tb_sys_array_stream_ctrl.sv
// tb_sys_array_stream_ctrl: randomized runs against a matrix-multiply
// core model plus directed backpressure, error and reset scenarios.

module tb_sys_array_stream_ctrl;

    localparam int TO = 16;

    logic        clk = 1'b0;
    logic        nrst = 1'b0;
    logic        ap_start = 1'b0;
    logic        ap_done;
    logic        ap_ready;
    logic        ap_idle;
    logic        ap_err;
    logic [1:0]  err_code;
    logic        s_valid = 1'b0;
    logic        s_ready;
    logic [63:0] s_data = '0;
    logic        core_in_valid;
    logic [63:0] core_in_data;
    logic        core_in_ready = 1'b0;
    logic        core_out_valid = 1'b0;
    logic [63:0] core_out_data = '0;
    logic        core_out_ready;
    logic        core_err = 1'b0;
    logic        m_valid;
    logic        m_ready = 1'b0;
    logic [63:0] m_data;
    logic        m_last;

    always #5 clk = ~clk;

    sys_array_stream_ctrl #(
        .M(2), .N(2), .K(2), .BW(2),
        .FIFO_DEPTH(4), .TIMEOUT_CYC(TO)
    ) dut (
        .clk(clk), .nrst(nrst), .ap_start(ap_start),
        .ap_done(ap_done), .ap_ready(ap_ready),
        .ap_idle(ap_idle), .ap_err(ap_err),
        .err_code(err_code),
        .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data),
        .core_in_valid(core_in_valid),
        .core_in_data(core_in_data),
        .core_in_ready(core_in_ready),
        .core_out_valid(core_out_valid),
        .core_out_data(core_out_data),
        .core_out_ready(core_out_ready),
        .core_err(core_err),
        .m_valid(m_valid), .m_ready(m_ready),
        .m_data(m_data), .m_last(m_last)
    );

    typedef struct {
        logic [63:0] d;
        bit          chk_last;
        bit          last;
    } exp_t;

    exp_t exp_q[$];
    int checks = 0;
    int errors = 0;

    task automatic chk(input string nm, input logic [63:0] got,
                       input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h exp %0h", nm, got, exp);
        end
    endtask

    task automatic push_exp(input logic [63:0] d, input bit cl,
                            input bit l);
        exp_t e;
        e.d = d;
        e.chk_last = cl;
        e.last = l;
        exp_q.push_back(e);
    endtask

    // Core model: A (2x2) then B (2x2) row-major, C = A*B row-major
    function automatic logic [127:0] matmul(input logic [255:0] w);
        logic [127:0] c;
        logic [31:0]  acc;
        c = '0;
        for (int i = 0; i < 2; i++) begin
            for (int j = 0; j < 2; j++) begin
                acc = '0;
                for (int k = 0; k < 2; k++) begin
                    acc = acc + w[32*(i*2+k) +: 32] *
                                w[32*(4+k*2+j) +: 32];
                end
                c[32*(i*2+j) +: 32] = acc;
            end
        end
        return c;
    endfunction

    always @(negedge clk) begin
        if (nrst && m_valid && m_ready) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL m_unexpected got %0h", m_data);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                if (m_data !== e.d ||
                    (e.chk_last && m_last !== e.last)) begin
                    errors++;
                    $display("FAIL m_beat got %0h last %b exp %0h last %b",
                             m_data, m_last, e.d, e.last);
                end
            end
        end
    end

    task automatic start();
        ap_start = 1'b1;
        @(posedge clk); #1;
        ap_start = 1'b0;
    endtask

    task automatic send(input int n);
        core_in_ready = 1'b1;
        for (int i = 0; i < n; i++) begin
            s_valid = 1'b1;
            s_data = {$urandom, $urandom};
            @(negedge clk);
            chk("send_s_ready", s_ready, 1);
            @(posedge clk); #1;
        end
        s_valid = 1'b0;
    endtask

    task automatic do_run(input int mpct);
        logic [255:0] win;
        logic [255:0] wcore;
        logic [127:0] c;
        logic [63:0]  pend[$];
        int sent;
        int got;
        bit done;
        bit comp;
        sent = 0;
        got = 0;
        done = 0;
        comp = 0;
        wcore = '0;
        for (int i = 0; i < 8; i++) win[32*i +: 32] = $urandom;
        c = matmul(win);
        push_exp(c[63:0], 1, 0);
        push_exp(c[127:64], 1, 1);
        start();
        for (int cyc = 0; cyc < 300; cyc++) begin
            s_valid = (sent < 4);
            s_data = (sent < 4) ? win[64*sent +: 64] : '0;
            core_in_ready = $urandom_range(0, 1) == 1;
            m_ready = $urandom_range(0, 99) < mpct;
            core_out_valid = (pend.size() > 0) &&
                             ($urandom_range(0, 9) < 7);
            core_out_data = (pend.size() > 0) ? pend[0] : '0;
            @(negedge clk);
            if (ap_done) begin
                done = 1;
                break;
            end
            if (core_in_valid && core_in_ready && got < 4) begin
                wcore[64*got +: 64] = core_in_data;
                got++;
            end
            if (s_valid && s_ready) sent++;
            if (core_out_valid && core_out_ready) void'(pend.pop_front());
            if (got == 4 && !comp) begin
                logic [127:0] cc;
                cc = matmul(wcore);
                pend.push_back(cc[63:0]);
                pend.push_back(cc[127:64]);
                comp = 1;
            end
            @(posedge clk); #1;
        end
        chk("run_done", done, 1);
        chk("run_ready", ap_ready, 1);
        chk("run_err", ap_err, 0);
        chk("run_code", err_code, 0);
        chk("run_q_empty", exp_q.size(), 0);
        @(posedge clk); #1;
        s_valid = 1'b0;
        core_in_ready = 1'b0;
        core_out_valid = 1'b0;
        m_ready = 1'b0;
        @(negedge clk);
        chk("run_done_pulse", ap_done, 0);
        chk("run_idle", ap_idle, 1);
        exp_q.delete();
        @(posedge clk); #1;
    endtask

    task automatic bp_test();
        logic [63:0] d[5];
        int bad;
        int n;
        bit done;
        bad = 0;
        done = 0;
        for (int i = 0; i < 5; i++) d[i] = {$urandom, $urandom};
        start();
        m_ready = 1'b0;
        send(4);
        for (int i = 0; i < 4; i++) begin
            core_out_valid = 1'b1;
            core_out_data = d[i];
            @(negedge clk);
            chk("bp_co_ready", core_out_ready, 1);
            push_exp(d[i], i < 2, i == 1);
            @(posedge clk); #1;
        end
        core_out_data = d[4];
        @(negedge clk);
        chk("bp_full", core_out_ready, 0);
        @(posedge clk); #1;
        core_out_valid = 1'b0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (m_data !== d[0] || !m_valid || ap_done) bad++;
            @(posedge clk); #1;
        end
        chk("bp_hold", bad, 0);
        m_ready = 1'b1;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (ap_done) begin
                done = 1;
                break;
            end
            @(posedge clk); #1;
        end
        chk("bp_done", done, 1);
        chk("bp_err", ap_err, 0);
        @(posedge clk); #1;
        n = 0;
        while (m_valid && n < 10) begin
            @(posedge clk); #1;
            n++;
        end
        chk("bp_q_empty", exp_q.size(), 0);
        m_ready = 1'b0;
        exp_q.delete();
    endtask

    task automatic timeout_test();
        int n;
        bit done;
        n = 0;
        done = 0;
        start();
        send(3);
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            n++;
            if (ap_done) begin
                done = 1;
                break;
            end
            @(posedge clk); #1;
        end
        chk("to_done", done, 1);
        chk("to_latency", (n >= TO && n <= TO + 2), 1);
        chk("to_ready", ap_ready, 1);
        chk("to_err", ap_err, 1);
        chk("to_code", err_code, 2'b01);
        @(posedge clk); #1;
        @(negedge clk);
        chk("to_idle", ap_idle, 1);
        chk("to_sticky", ap_err, 1);
        @(posedge clk); #1;
    endtask

    task automatic core_err_test(input bit with_to);
        int early;
        early = 0;
        start();
        if (with_to) begin
            send(1);
            for (int i = 0; i < TO - 1; i++) begin
                @(negedge clk);
                if (ap_done) early++;
                @(posedge clk); #1;
            end
            chk("ce_no_early", early, 0);
        end else begin
            send(2);
            @(negedge clk);
            chk("ce_clear", ap_err, 0);
            @(posedge clk); #1;
        end
        core_err = 1'b1;
        @(negedge clk);
        chk("ce_not_yet", ap_done, 0);
        @(posedge clk); #1;
        core_err = 1'b0;
        @(negedge clk);
        chk("ce_done", ap_done, 1);
        chk("ce_err", ap_err, 1);
        chk("ce_code", err_code, 2'b10);
        @(posedge clk); #1;
        @(negedge clk);
        chk("ce_idle", ap_idle, 1);
        @(posedge clk); #1;
    endtask

    task automatic stray_reset_test();
        core_out_valid = 1'b1;
        core_out_data = {$urandom, $urandom};
        @(negedge clk);
        chk("stray_ready", core_out_ready, 1);
        @(posedge clk); #1;
        core_out_valid = 1'b0;
        @(negedge clk);
        chk("stray_err", ap_err, 1);
        chk("stray_code", err_code, 2'b11);
        chk("stray_mvalid", m_valid, 0);
        chk("stray_idle", ap_idle, 1);
        @(posedge clk); #1;
        start();
        @(negedge clk);
        chk("stray_clr_err", ap_err, 0);
        chk("stray_clr_code", err_code, 0);
        @(posedge clk); #1;
        m_ready = 1'b0;
        send(4);
        for (int i = 0; i < 2; i++) begin
            core_out_valid = 1'b1;
            core_out_data = {$urandom, $urandom};
            @(posedge clk); #1;
        end
        core_out_valid = 1'b0;
        s_valid = 1'b1;
        @(negedge clk);
        chk("rst_pre_mvalid", m_valid, 1);
        chk("rst_pre_idle", ap_idle, 0);
        #2 nrst = 1'b0;
        #1;
        chk("rst_idle", ap_idle, 1);
        chk("rst_mvalid", m_valid, 0);
        chk("rst_mlast", m_last, 0);
        chk("rst_done", ap_done, 0);
        chk("rst_ready", ap_ready, 0);
        chk("rst_err", ap_err, 0);
        chk("rst_code", err_code, 0);
        chk("rst_s_ready", s_ready, 0);
        chk("rst_cin_valid", core_in_valid, 0);
        s_valid = 1'b0;
        exp_q.delete();
        @(posedge clk); #1;
        @(posedge clk); #1;
        nrst = 1'b1;
        @(posedge clk); #1;
    endtask

    initial begin
        #12;
        chk("reset_idle", ap_idle, 1);
        chk("reset_done", ap_done, 0);
        chk("reset_err", ap_err, 0);
        chk("reset_code", err_code, 0);
        chk("reset_mvalid", m_valid, 0);
        chk("reset_s_ready", s_ready, 0);
        @(posedge clk); #1;
        nrst = 1'b1;
        @(posedge clk); #1;
        for (int r = 0; r < 20; r++) do_run($urandom_range(30, 100));
        bp_test();
        timeout_test();
        core_err_test(0);
        core_err_test(1);
        stray_reset_test();
        do_run(100);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
